row_fetch_scheduler: RTL and testbench

- Sequences the four 16-character screen rows (text, binary, hex/dec, progress generators) for the 128x64 OLED page driver.
- Per pixel-byte request: decodes the screen address into row, character index and byte-within-glyph. Waits out the row generator latency, then translates character bytes through the font ROM. Graphic rows bypass the font ROM.
- Returns one pixel byte per request over a req/valid handshake.

---
 rtl/row_fetch_scheduler.sv | 177 +++++++++++++++++
 tb/tb_row_fetch_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// row_fetch_scheduler
//
// Produces one pixel byte per request for the 128x64 OLED page driver.  The
// screen is four 16-character rows; each row has its own generator (text,
// binary, hex/dec, progress bar).  A request address is split into row, char
// index, glyph half and glyph column.  Text rows return a character code that
// is translated through the shared font ROM.  Graphic rows return raw pixel
// bytes and bypass the ROM.  Disabled rows answer 8'h00 immediately.
//
// Ports
//   clk              system clock
//   resetn           asynchronous active-low reset
//   pixelReq         request one byte (only looked at while idle)
//   pixelAddress     [9:8] row, [7] bottom glyph half, [6:3] char, [2:0] column
//   pixelData        result byte, held after the valid pulse
//   pixelValid       one-cycle completion pulse
//   busy             high from accept until the cycle after pixelValid
//   rowEnable        per-row enable, disabled rows return 8'h00
//   charIndex        char index shared by all text row generators
//   rowPixelAddress  captured request address, for graphic row generators
//   rowByte0..3      row generator outputs
//   fontAddr         {char code, half, column} into the font ROM
//   fontData         font ROM output
//
// State table
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | waiting for pixelReq, busy low
//   S_ROW_WAIT  | row generators settling on charIndex / rowPixelAddress
//   S_LATCH     | sample the addressed row byte; graphic -> done, text -> ROM
//   S_FONT_WAIT | font ROM settling on fontAddr
//   S_DONE      | pixelValid high for this single cycle
// -----------------------------------------------------------------------------
module row_fetch_scheduler #(
  parameter int unsigned ROW_LATENCY  = 2,       // 1..7
  parameter int unsigned FONT_LATENCY = 1,       // 1..7
  parameter logic [3:0]  GRAPHIC_ROWS = 4'b1000  // 1 = raw pixel row
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pixelReq,
  input  logic [9:0]  pixelAddress,
  output logic [7:0]  pixelData,
  output logic        pixelValid,
  output logic        busy,
  input  logic [3:0]  rowEnable,
  output logic [3:0]  charIndex,
  output logic [9:0]  rowPixelAddress,
  input  logic [7:0]  rowByte0,
  input  logic [7:0]  rowByte1,
  input  logic [7:0]  rowByte2,
  input  logic [7:0]  rowByte3,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_WAIT,
    S_LATCH,
    S_FONT_WAIT,
    S_DONE
  } state_t;

  // ROW_WAIT lasts ROW_LATENCY cycles, so the row byte is already stable when
  // LATCH samples it one cycle later.  FONT_WAIT lasts FONT_LATENCY+1 cycles
  // for the same reason: fontAddr is itself registered on leaving LATCH, so
  // fontData settles FONT_LATENCY edges after that and is sampled one edge on.
  localparam logic [2:0] ROW_TC  = 3'(ROW_LATENCY - 1);
  localparam logic [2:0] FONT_TC = 3'(FONT_LATENCY);

  state_t     state;
  logic [2:0] wait_cnt;

  // rowPixelAddress doubles as the captured request address for the whole
  // transaction, so later changes on pixelAddress cannot leak in.
  logic [1:0] cap_row;
  logic       cap_half;
  logic [2:0] cap_col;
  logic [7:0] row_byte_sel;
  logic [1:0] req_row;

  assign cap_row  = rowPixelAddress[9:8];
  assign cap_half = rowPixelAddress[7];
  assign cap_col  = rowPixelAddress[2:0];
  assign req_row  = pixelAddress[9:8];

  always_comb begin
    row_byte_sel = rowByte0;
    case (cap_row)
      2'd0:    row_byte_sel = rowByte0;
      2'd1:    row_byte_sel = rowByte1;
      2'd2:    row_byte_sel = rowByte2;
      default: row_byte_sel = rowByte3;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      wait_cnt        <= 3'd0;
      pixelData       <= 8'h00;
      pixelValid      <= 1'b0;
      busy            <= 1'b0;
      charIndex       <= 4'h0;
      rowPixelAddress <= 10'h000;
      fontAddr        <= 12'h000;
    end else begin
      case (state)
        S_IDLE: begin
          if (pixelReq) begin
            rowPixelAddress <= pixelAddress;
            charIndex       <= pixelAddress[6:3];
            busy            <= 1'b1;
            wait_cnt        <= 3'd0;
            if (rowEnable[req_row]) begin
              state <= S_ROW_WAIT;
            end else begin
              // Disabled row: answer at once without touching generators.
              pixelData  <= 8'h00;
              pixelValid <= 1'b1;
              state      <= S_DONE;
            end
          end
        end

        S_ROW_WAIT: begin
          if (wait_cnt == ROW_TC) begin
            wait_cnt <= 3'd0;
            state    <= S_LATCH;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        S_LATCH: begin
          if (GRAPHIC_ROWS[cap_row]) begin
            pixelData  <= row_byte_sel;
            pixelValid <= 1'b1;
            state      <= S_DONE;
          end else begin
            // Char code goes to the ROM untouched, control codes included.
            fontAddr <= {row_byte_sel, cap_half, cap_col};
            wait_cnt <= 3'd0;
            state    <= S_FONT_WAIT;
          end
        end

        S_FONT_WAIT: begin
          if (wait_cnt == FONT_TC) begin
            wait_cnt   <= 3'd0;
            pixelData  <= fontData;
            pixelValid <= 1'b1;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        S_DONE: begin
          pixelValid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          pixelValid <= 1'b0;
          busy       <= 1'b0;
          wait_cnt   <= 3'd0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for row_fetch_scheduler.  Two instances share the request inputs:
// index 0 uses the default latencies, index 1 uses ROW_LATENCY=4,
// FONT_LATENCY=3.  Each instance has its own row generators and font ROM,
// modelled as pure functions followed by a delay line of the stated latency.
// -----------------------------------------------------------------------------
module tb_row_fetch_scheduler;

  localparam int RL_A = 2;
  localparam int FL_A = 1;
  localparam int RL_B = 4;
  localparam int FL_B = 3;
  localparam logic [3:0] GFX = 4'b1000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pixelReq = 1'b0;
  logic [9:0] pixelAddress = 10'h000;
  logic [3:0] rowEnable = 4'hF;

  logic [7:0]  pd  [2];
  logic        pv  [2];
  logic        bsy [2];
  logic [3:0]  ci  [2];
  logic [9:0]  rpa [2];
  logic [11:0] fa  [2];
  logic [7:0]  fd  [2];
  logic [7:0]  rb  [2][4];
  logic [7:0]  corrupt [2] = '{8'h00, 8'h00};

  logic [7:0] text_mem [4][16];
  logic [7:0] rb_pipe [2][4][8] = '{default: 8'h00};
  logic [7:0] fd_pipe [2][8] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  row_fetch_scheduler #(.ROW_LATENCY(RL_A), .FONT_LATENCY(FL_A), .GRAPHIC_ROWS(GFX)) u_a (
    .clk(clk), .resetn(resetn), .pixelReq(pixelReq), .pixelAddress(pixelAddress),
    .pixelData(pd[0]), .pixelValid(pv[0]), .busy(bsy[0]), .rowEnable(rowEnable),
    .charIndex(ci[0]), .rowPixelAddress(rpa[0]),
    .rowByte0(rb[0][0]), .rowByte1(rb[0][1]), .rowByte2(rb[0][2]), .rowByte3(rb[0][3]),
    .fontAddr(fa[0]), .fontData(fd[0]));

  row_fetch_scheduler #(.ROW_LATENCY(RL_B), .FONT_LATENCY(FL_B), .GRAPHIC_ROWS(GFX)) u_b (
    .clk(clk), .resetn(resetn), .pixelReq(pixelReq), .pixelAddress(pixelAddress),
    .pixelData(pd[1]), .pixelValid(pv[1]), .busy(bsy[1]), .rowEnable(rowEnable),
    .charIndex(ci[1]), .rowPixelAddress(rpa[1]),
    .rowByte0(rb[1][0]), .rowByte1(rb[1][1]), .rowByte2(rb[1][2]), .rowByte3(rb[1][3]),
    .fontAddr(fa[1]), .fontData(fd[1]));

  // ---------------- reference content ----------------
  function automatic logic [7:0] gfx_byte(input logic [9:0] a);
    if (a == 10'h385) return 8'h0F;
    return 8'((a * 13) ^ (a >> 2) ^ 10'h0A5);
  endfunction

  function automatic logic [7:0] font_rom(input logic [11:0] a);
    if (a == 12'h410) return 8'h7C;
    return {a[3:0], a[7:4]} ^ a[11:4] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] row_gen(input int n, input logic [3:0] c, input logic [9:0] a);
    if (GFX[n]) return gfx_byte(a);
    return text_mem[n][c];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++) begin
        for (int i = 7; i > 0; i--) rb_pipe[d][n][i] <= rb_pipe[d][n][i-1];
        rb_pipe[d][n][0] <= row_gen(n, ci[d], rpa[d]);
      end
      for (int i = 7; i > 0; i--) fd_pipe[d][i] <= fd_pipe[d][i-1];
      fd_pipe[d][0] <= font_rom(fa[d]);
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_rb
    assign rb[0][n] = rb_pipe[0][n][RL_A-1] ^ corrupt[0];
    assign rb[1][n] = rb_pipe[1][n][RL_B-1] ^ corrupt[1];
  end
  assign fd[0] = fd_pipe[0][FL_A-1];
  assign fd[1] = fd_pipe[1][FL_B-1];

  // ---------------- expectation model ----------------
  function automatic int exp_lat(input int d, input logic [9:0] a, input logic [3:0] en);
    int rl = (d == 0) ? RL_A : RL_B;
    int fl = (d == 0) ? FL_A : FL_B;
    if (!en[a[9:8]]) return 1;
    if (GFX[a[9:8]]) return rl + 2;
    return rl + fl + 3;
  endfunction

  function automatic logic [11:0] exp_faddr(input logic [9:0] a);
    return {text_mem[a[9:8]][a[6:3]], a[7], a[2:0]};
  endfunction

  function automatic logic [7:0] exp_data(input logic [9:0] a, input logic [3:0] en);
    if (!en[a[9:8]]) return 8'h00;
    if (GFX[a[9:8]]) return gfx_byte(a);
    return font_rom(exp_faddr(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_pd%0d", tag, d), 32'(pd[d]), 0);
      check($sformatf("%s_pv%0d", tag, d), 32'(pv[d]), 0);
      check($sformatf("%s_busy%0d", tag, d), 32'(bsy[d]), 0);
      check($sformatf("%s_ci%0d", tag, d), 32'(ci[d]), 0);
      check($sformatf("%s_rpa%0d", tag, d), 32'(rpa[d]), 0);
      check($sformatf("%s_fa%0d", tag, d), 32'(fa[d]), 0);
    end
  endtask

  // One request on both instances; pixelAddress/rowEnable are scrambled
  // right after accept.  corrupt_a flips instance 0's row bytes once it has
  // moved past LATCH.
  task automatic do_txn(input string tag, input logic [9:0] addr, input logic [3:0] en,
                        input bit corrupt_a);
    int first [2];
    int pulses [2];
    logic [7:0] got [2];
    logic [11:0] fa_before [2];
    int maxl;
    bit is_text;
    is_text = en[addr[9:8]] && !GFX[addr[9:8]];
    maxl = exp_lat(1, addr, en);
    @(negedge clk);
    pixelAddress = addr;
    rowEnable = en;
    pixelReq = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fa_before[d] = fa[d];
      first[d] = 0;
      pulses[d] = 0;
      got[d] = 8'h00;
    end
    @(posedge clk);
    #1;
    pixelReq = 1'b0;
    pixelAddress = 10'($urandom);
    rowEnable = 4'($urandom);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_busy%0d", tag, d), 32'(bsy[d]), 1);
      check($sformatf("%s_ci%0d", tag, d), 32'(ci[d]), 32'(addr[6:3]));
      check($sformatf("%s_rpa%0d", tag, d), 32'(rpa[d]), 32'(addr));
    end
    for (int k = 1; k <= maxl + 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (pv[d]) begin
          pulses[d]++;
          if (first[d] == 0) begin
            first[d] = k;
            got[d] = pd[d];
          end
        end
        if (first[d] != 0 && k == first[d] + 1)
          check($sformatf("%s_busy_after%0d", tag, d), 32'(bsy[d]), 0);
      end
      if (corrupt_a && is_text && k == RL_A + 2) corrupt[0] = 8'hFF;
      @(posedge clk);
      #1;
    end
    corrupt[0] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_lat%0d", tag, d), 32'(first[d]), 32'(exp_lat(d, addr, en)));
      check($sformatf("%s_data%0d", tag, d), 32'(got[d]), 32'(exp_data(addr, en)));
      check($sformatf("%s_pulses%0d", tag, d), 32'(pulses[d]), 1);
      check($sformatf("%s_held%0d", tag, d), 32'(pd[d]), 32'(exp_data(addr, en)));
      if (is_text)
        check($sformatf("%s_fa%0d", tag, d), 32'(fa[d]), 32'(exp_faddr(addr)));
      else
        check($sformatf("%s_fa_kept%0d", tag, d), 32'(fa[d]), 32'(fa_before[d]));
    end
  endtask

  initial begin
    logic [9:0] addr1, drv2, a;
    int lat1, lat2, pulses, second_k;
    logic [7:0] second_data;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) text_mem[r][c] = 8'($urandom);
    text_mem[0][0] = 8'h41;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    do_txn("text_A", 10'h000, 4'hF, 1'b0);
    do_txn("gfx_row3", 10'h385, 4'hF, 1'b0);
    do_txn("disabled_row1", 10'h100, 4'b1101, 1'b0);
    do_txn("bottom_half", 10'h08A, 4'hF, 1'b0);
    do_txn("row_change_after_latch", 10'h0D3, 4'hF, 1'b1);

    // Held request with a moving address (instance 0 checked)
    addr1 = 10'h01B;
    lat1 = exp_lat(0, addr1, 4'hF);
    @(negedge clk);
    rowEnable = 4'hF;
    pixelAddress = addr1;
    pixelReq = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    second_k = 0;
    second_data = 8'h00;
    drv2 = 10'h000;
    lat2 = 0;
    for (int k = 1; k <= lat1 + 9; k++) begin
      if (pv[0]) begin
        pulses++;
        if (k == lat1) check("held_first_data", 32'(pd[0]), 32'(exp_data(addr1, 4'hF)));
        else if (second_k == 0) begin
          second_k = k;
          second_data = pd[0];
        end
      end
      if (k == lat1 + 1) check("held_ignore_mid", 32'(rpa[0]), 32'(addr1));
      if (k == lat1 + 2) begin
        check("held_second_rpa", 32'(rpa[0]), 32'(drv2));
        pixelReq = 1'b0;
      end
      if (k <= lat1 + 1) begin
        pixelAddress = 10'($urandom);
        if (k == lat1 + 1) begin
          drv2 = pixelAddress;
          lat2 = exp_lat(0, drv2, 4'hF);
        end
      end
      @(posedge clk);
      #1;
    end
    check("held_pulses", 32'(pulses), 2);
    check("held_second_at", 32'(second_k), 32'(lat1 + 1 + lat2));
    check("held_second_data", 32'(second_data), 32'(exp_data(drv2, 4'hF)));
    repeat (14) @(posedge clk);

    // Reset while instance 0 sits in FONT_WAIT
    @(negedge clk);
    pixelAddress = 10'h029;
    rowEnable = 4'hF;
    pixelReq = 1'b1;
    @(posedge clk);
    #1;
    pixelReq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midreset_no_valid0", 32'(pv[0]), 0);
      check("midreset_no_valid1", 32'(pv[1]), 0);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_txn("after_reset", 10'h0F8, 4'hF, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 20; t++) begin
      text_mem[$urandom_range(0, 3)][$urandom_range(0, 15)] = 8'($urandom);
      a = 10'($urandom);
      do_txn($sformatf("rand%0d", t), a, 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
